// File: rtl/instr_encoder_if.sv
// Field-bundle input and encoded-word output channels of the instruction encoder.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes ADD/SUB/ADDI/NOP field bundles into RV32I words, tags each with a
// sequential byte address and streams them through a 2-entry output FIFO.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_INSTR = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  instr_encoder_if.slave        bus,
  output logic [15:0]           instr_count,
  output logic                  err_imm
);

  localparam int unsigned CNT_W     = 16;
  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (MAX_INSTR - 1));
  localparam logic [1:0]  OP_ADD    = 2'b00;
  localparam logic [1:0]  OP_SUB    = 2'b01;
  localparam logic [1:0]  OP_ADDI   = 2'b10;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } entry_t;

  entry_t             head_q, tail_q, head_d, tail_d;
  logic [1:0]         count_q, count_d;
  logic [31:0]        addr_q, addr_d;
  logic               err_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               push_c, pop_c;
  logic               imm_bad_c;
  logic [31:0]        word_c;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = head_q.instr;
  assign bus.out_addr  = head_q.addr;

  assign push_c = bus.in_valid && in_ready_q;
  assign pop_c  = out_valid_q && bus.out_ready;

  // Immediates that do not fit 12 bits are truncated but flagged.
  assign imm_bad_c = (bus.in_op == OP_ADDI) &&
                     (bus.in_imm != {{20{bus.in_imm[11]}}, bus.in_imm[11:0]});

  always_comb begin
    word_c = NOP_WORD;
    case (bus.in_op)
      OP_ADD:  word_c = {7'b0000000, bus.in_rs2, bus.in_rs1, 3'b000, bus.in_rd, 7'b0110011};
      OP_SUB:  word_c = {7'b0100000, bus.in_rs2, bus.in_rs1, 3'b000, bus.in_rd, 7'b0110011};
      OP_ADDI: word_c = {bus.in_imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, 7'b0010011};
      default: word_c = NOP_WORD;
    endcase
  end

  // FIFO, address counter and status next-state; pop is applied before push
  // so a simultaneous push into a one-entry FIFO lands in the head slot.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    addr_d  = addr_q;
    err_d   = err_imm;
    cnt_d   = instr_count;

    if (pop_c) begin
      cnt_d   = instr_count + CNT_W'(1);
      head_d  = (count_q == 2'd2) ? tail_q : '0;
      tail_d  = '0;
      count_d = count_q - 2'd1;
    end

    if (push_c) begin
      if (count_d == 2'd0) head_d = {word_c, addr_q};
      else                 tail_d = {word_c, addr_q};
      count_d = count_d + 2'd1;
      addr_d  = (addr_q == LAST_ADDR) ? BASE_ADDR : addr_q + 32'd4;
      if (imm_bad_c) err_d = 1'b1;
    end

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = 2'd0;
      addr_d  = BASE_ADDR;
      err_d   = 1'b0;
      cnt_d   = instr_count;
    end

    out_valid_d = (count_d != 2'd0);
    in_ready_d  = (count_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= 2'd0;
      addr_q      <= BASE_ADDR;
      err_imm     <= 1'b0;
      instr_count <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      err_imm     <= err_d;
      instr_count <= cnt_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a 4-slot address space at base 0x100.
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [15:0] instr_count;
  logic        err_imm;
  int          n_checks = 0;
  int          n_fail   = 0;

  instr_encoder_if bif ();

  instr_encoder #(.BASE_ADDR(BASE), .MAX_INSTR(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .bus         (bif.slave),
    .instr_count (instr_count),
    .err_imm     (err_imm)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    bif.in_valid = v;
    bif.in_op    = op;
    bif.in_rd    = rd;
    bif.in_rs1   = rs1;
    bif.in_rs2   = rs2;
    bif.in_imm   = imm;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; bif.out_ready = 1'b0;
    drive(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 32'd0);
    tick(); tick();
    rst = 1'b0;
    n_checks++;
    if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1 || bif.out_instr !== 32'd0 ||
        bif.out_addr !== 32'd0 || instr_count !== 16'd0 || err_imm !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b r=%b i=%h a=%h c=%0d e=%b, need 0 1 0 0 0 0",
               bif.out_valid, bif.in_ready, bif.out_instr, bif.out_addr, instr_count, err_imm);
    end
  endtask

  task automatic test_add();
    bif.out_ready = 1'b1;
    drive(1'b1, 2'b00, 5'd3, 5'd1, 5'd2, 32'd0);
    tick();
    drive(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 32'd0);
    n_checks++;
    if (bif.out_valid !== 1'b1 || bif.out_instr !== 32'h002081B3 || bif.out_addr !== BASE) begin
      n_fail++;
      $display("FAIL add_word: got v=%b i=%h a=%h, need 1 002081b3 %h",
               bif.out_valid, bif.out_instr, bif.out_addr, BASE);
    end
    tick();
    n_checks++;
    if (bif.out_valid !== 1'b0 || instr_count !== 16'd1 || bif.out_instr !== 32'd0) begin
      n_fail++;
      $display("FAIL add_pop: got v=%b c=%0d i=%h, need 0 1 0", bif.out_valid, instr_count, bif.out_instr);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_i [3];
    logic [31:0] exp_a [3];
    exp_i[0] = 32'h407302B3; exp_i[1] = 32'hFFF00093; exp_i[2] = 32'h00000013;
    exp_a[0] = BASE + 32'd4; exp_a[1] = BASE + 32'd8; exp_a[2] = BASE + 32'd12;
    bif.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: drive(1'b1, 2'b01, 5'd5, 5'd6, 5'd7, 32'd0);
        1: drive(1'b1, 2'b10, 5'd1, 5'd0, 5'd9, 32'hFFFF_FFFF);
        default: drive(1'b1, 2'b11, 5'd7, 5'd8, 5'd9, 32'h1234_5678);
      endcase
      tick();
      n_checks++;
      if (bif.out_valid !== 1'b1 || bif.out_instr !== exp_i[i] || bif.out_addr !== exp_a[i]) begin
        n_fail++;
        $display("FAIL b2b_word%0d: got v=%b i=%h a=%h, need 1 %h %h",
                 i, bif.out_valid, bif.out_instr, bif.out_addr, exp_i[i], exp_a[i]);
      end
    end
    drive(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 32'd0);
    tick();
    n_checks++;
    if (bif.out_valid !== 1'b0 || instr_count !== 16'd4 || err_imm !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: got v=%b c=%0d e=%b, need 0 4 0", bif.out_valid, instr_count, err_imm);
    end
  endtask

  task automatic test_imm_err();
    bif.out_ready = 1'b1;
    drive(1'b1, 2'b10, 5'd2, 5'd0, 5'd0, 32'd2048);
    tick();
    n_checks++;
    if (bif.out_instr !== 32'h80000113 || bif.out_addr !== BASE || err_imm !== 1'b1) begin
      n_fail++;
      $display("FAIL imm_big: got i=%h a=%h e=%b, need 80000113 %h 1", bif.out_instr, bif.out_addr, err_imm, BASE);
    end
    drive(1'b1, 2'b00, 5'd3, 5'd1, 5'd2, 32'd0);
    tick();
    drive(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 32'd0);
    n_checks++;
    if (bif.out_instr !== 32'h002081B3 || bif.out_addr !== BASE + 32'd4 || err_imm !== 1'b1) begin
      n_fail++;
      $display("FAIL imm_sticky: got i=%h a=%h e=%b, need 002081b3 %h 1",
               bif.out_instr, bif.out_addr, err_imm, BASE + 32'd4);
    end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (err_imm !== 1'b0 || instr_count !== 16'd6) begin
      n_fail++;
      $display("FAIL imm_flush: got e=%b c=%0d, need 0 6", err_imm, instr_count);
    end
  endtask

  task automatic test_backpressure();
    bif.out_ready = 1'b0;
    drive(1'b1, 2'b00, 5'd3, 5'd1, 5'd2, 32'd0);
    tick();
    n_checks++;
    if (bif.in_ready !== 1'b1 || bif.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_first: got r=%b v=%b, need 1 1", bif.in_ready, bif.out_valid);
    end
    drive(1'b1, 2'b01, 5'd5, 5'd6, 5'd7, 32'd0);
    tick();
    n_checks++;
    if (bif.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full: got r=%b, need 0", bif.in_ready);
    end
    drive(1'b1, 2'b11, 5'd0, 5'd0, 5'd0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (bif.in_ready !== 1'b0 || bif.out_instr !== 32'h002081B3 || bif.out_addr !== BASE) begin
        n_fail++;
        $display("FAIL bp_stall%0d: got r=%b i=%h a=%h, need 0 002081b3 %h",
                 i, bif.in_ready, bif.out_instr, bif.out_addr, BASE);
      end
    end
    bif.out_ready = 1'b1;
    tick();
    n_checks++;
    if (bif.in_ready !== 1'b1 || bif.out_instr !== 32'h407302B3 || bif.out_addr !== BASE + 32'd4) begin
      n_fail++;
      $display("FAIL bp_pop1: got r=%b i=%h a=%h, need 1 407302b3 %h",
               bif.in_ready, bif.out_instr, bif.out_addr, BASE + 32'd4);
    end
    tick();
    drive(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 32'd0);
    n_checks++;
    if (bif.out_instr !== 32'h00000013 || bif.out_addr !== BASE + 32'd8) begin
      n_fail++;
      $display("FAIL bp_third: got i=%h a=%h, need 00000013 %h", bif.out_instr, bif.out_addr, BASE + 32'd8);
    end
    tick();
    n_checks++;
    if (bif.out_valid !== 1'b0 || instr_count !== 16'd9) begin
      n_fail++;
      $display("FAIL bp_end: got v=%b c=%0d, need 0 9", bif.out_valid, instr_count);
    end
  endtask

  task automatic test_addr_wrap();
    logic [31:0] exp_a;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bif.out_ready = 1'b1;
    drive(1'b1, 2'b11, 5'd1, 5'd1, 5'd1, 32'd5);
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_a = BASE + 32'(4 * (i % 4));
      n_checks++;
      if (bif.out_valid !== 1'b1 || bif.out_instr !== 32'h00000013 || bif.out_addr !== exp_a) begin
        n_fail++;
        $display("FAIL wrap_addr%0d: got v=%b i=%h a=%h, need 1 00000013 %h",
                 i, bif.out_valid, bif.out_instr, bif.out_addr, exp_a);
      end
    end
    drive(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 32'd0);
    tick();
  endtask

  task automatic test_clear_full(input logic use_rst);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bif.out_ready = 1'b0;
    drive(1'b1, 2'b10, 5'd4, 5'd1, 5'd0, 32'd4096);
    tick();
    drive(1'b1, 2'b00, 5'd3, 5'd1, 5'd2, 32'd0);
    tick();
    drive(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 32'd0);
    n_checks++;
    if (bif.in_ready !== 1'b0 || err_imm !== 1'b1 || bif.out_addr !== BASE) begin
      n_fail++;
      $display("FAIL clear%0d_pre: got r=%b e=%b a=%h, need 0 1 %h", use_rst, bif.in_ready, err_imm, bif.out_addr, BASE);
    end
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0;
    n_checks++;
    if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1 || err_imm !== 1'b0 || bif.out_instr !== 32'd0 ||
        instr_count !== (use_rst ? 16'd0 : 16'd14)) begin
      n_fail++;
      $display("FAIL clear%0d_post: got v=%b r=%b e=%b i=%h c=%0d", use_rst,
               bif.out_valid, bif.in_ready, err_imm, bif.out_instr, instr_count);
    end
    bif.out_ready = 1'b1;
    drive(1'b1, 2'b01, 5'd5, 5'd6, 5'd7, 32'd0);
    tick();
    drive(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 32'd0);
    n_checks++;
    if (bif.out_instr !== 32'h407302B3 || bif.out_addr !== BASE) begin
      n_fail++;
      $display("FAIL clear%0d_next: got i=%h a=%h, need 407302b3 %h", use_rst, bif.out_instr, bif.out_addr, BASE);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_imm_err();
    test_backpressure();
    test_addr_wrap();
    test_clear_full(1'b0);
    test_clear_full(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
